// File: rtl/mandel_scheduler.sv
// rtl/mandel_scheduler.sv - Mandelbrot frame scheduler feeding a fixed-latency z^2+c core
// Optional per-frame in-set counter output enabled by MANDEL_SCHED_STATS_EN.
module mandel_scheduler #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 9,
  parameter int COORD_WIDTH = 16,
  parameter int H_RES       = 32,
  parameter int V_RES       = 16,
  parameter int CORE_LAT    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  max_iter,
  input  logic [COORD_WIDTH-1:0] re_start,
  input  logic [COORD_WIDTH-1:0] im_start,
  input  logic [COORD_WIDTH-1:0] re_step,
  input  logic [COORD_WIDTH-1:0] im_step,
  output logic                   busy,
  output logic                   done,
  output logic                   core_in_valid,
  output logic [COORD_WIDTH-1:0] core_z_re,
  output logic [COORD_WIDTH-1:0] core_z_im,
  output logic [COORD_WIDTH-1:0] core_c_re,
  output logic [COORD_WIDTH-1:0] core_c_im,
  input  logic                   core_out_valid,
  input  logic [COORD_WIDTH-1:0] core_z_re_o,
  input  logic [COORD_WIDTH-1:0] core_z_im_o,
  input  logic                   core_escaped,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data
`ifdef MANDEL_SCHED_STATS_EN
  ,
  output logic [ADDR_WIDTH:0]    in_set_count
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  logic [1:0]             state_q, state_d;
  logic [DATA_WIDTH-1:0]  max_iter_q, max_iter_d;
  logic [COORD_WIDTH-1:0] re_start_q, re_start_d;
  logic [COORD_WIDTH-1:0] re_step_q, re_step_d;
  logic [COORD_WIDTH-1:0] im_step_q, im_step_d;
  logic [X_W-1:0]         x_q, x_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic [ADDR_WIDTH-1:0]  pix_addr_q, pix_addr_d;
  logic [COORD_WIDTH-1:0] re_acc_q, re_acc_d;
  logic [COORD_WIDTH-1:0] im_acc_q, im_acc_d;

  // Issue register: drives the core operands directly
  logic                   iss_valid_q, iss_valid_d;
  logic [COORD_WIDTH-1:0] iss_z_re_q, iss_z_re_d;
  logic [COORD_WIDTH-1:0] iss_z_im_q, iss_z_im_d;
  logic [COORD_WIDTH-1:0] iss_c_re_q, iss_c_re_d;
  logic [COORD_WIDTH-1:0] iss_c_im_q, iss_c_im_d;
  logic [DATA_WIDTH-1:0]  iss_iter_q, iss_iter_d;
  logic [ADDR_WIDTH-1:0]  iss_addr_q, iss_addr_d;

  logic [CORE_LAT-1:0]                  sb_valid_q, sb_valid_d;
  logic [CORE_LAT-1:0][COORD_WIDTH-1:0] sb_c_re_q, sb_c_re_d;
  logic [CORE_LAT-1:0][COORD_WIDTH-1:0] sb_c_im_q, sb_c_im_d;
  logic [CORE_LAT-1:0][DATA_WIDTH-1:0]  sb_iter_q, sb_iter_d;
  logic [CORE_LAT-1:0][ADDR_WIDTH-1:0]  sb_addr_q, sb_addr_d;

  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;

  logic                   start_acc;
  logic                   ret_valid;
  logic [DATA_WIDTH:0]    iter_next;
  logic                   retire;
  logic                   recirc;
  logic                   inject;
  logic                   last_pix;
  logic                   any_valid;

  always_comb begin
    state_d     = state_q;
    max_iter_d  = max_iter_q;
    re_start_d  = re_start_q;
    re_step_d   = re_step_q;
    im_step_d   = im_step_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_addr_d  = pix_addr_q;
    re_acc_d    = re_acc_q;
    im_acc_d    = im_acc_q;
    iss_valid_d = 1'b0;
    iss_z_re_d  = iss_z_re_q;
    iss_z_im_d  = iss_z_im_q;
    iss_c_re_d  = iss_c_re_q;
    iss_c_im_d  = iss_c_im_q;
    iss_iter_d  = iss_iter_q;
    iss_addr_d  = iss_addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    start_acc = (state_q == S_IDLE) && start;
    ret_valid = sb_valid_q[CORE_LAT-1] && core_out_valid;
    iter_next = {1'b0, sb_iter_q[CORE_LAT-1]} + (DATA_WIDTH+1)'(1);
    retire    = ret_valid && (core_escaped || (iter_next == {1'b0, max_iter_q}));
    recirc    = ret_valid && !retire;
    inject    = (state_q == S_RUN) && !recirc;
    last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);

    sb_valid_d[0] = iss_valid_q;
    sb_c_re_d[0]  = iss_c_re_q;
    sb_c_im_d[0]  = iss_c_im_q;
    sb_iter_d[0]  = iss_iter_q;
    sb_addr_d[0]  = iss_addr_q;
    for (int k = 1; k < CORE_LAT; k++) begin
      sb_valid_d[k] = sb_valid_q[k-1];
      sb_c_re_d[k]  = sb_c_re_q[k-1];
      sb_c_im_d[k]  = sb_c_im_q[k-1];
      sb_iter_d[k]  = sb_iter_q[k-1];
      sb_addr_d[k]  = sb_addr_q[k-1];
    end

    any_valid = iss_valid_q;
    for (int k = 0; k < CORE_LAT; k++) begin
      any_valid = any_valid | sb_valid_q[k];
    end

    if (retire) begin
      wr_en_d   = 1'b1;
      wr_addr_d = sb_addr_q[CORE_LAT-1];
      wr_data_d = core_escaped ? sb_iter_q[CORE_LAT-1] : max_iter_q;
    end

    // Returning points own the issue slot; fresh pixels only fill freed slots
    if (recirc) begin
      iss_valid_d = 1'b1;
      iss_z_re_d  = core_z_re_o;
      iss_z_im_d  = core_z_im_o;
      iss_c_re_d  = sb_c_re_q[CORE_LAT-1];
      iss_c_im_d  = sb_c_im_q[CORE_LAT-1];
      iss_iter_d  = iter_next[DATA_WIDTH-1:0];
      iss_addr_d  = sb_addr_q[CORE_LAT-1];
    end else if (inject) begin
      iss_valid_d = 1'b1;
      iss_z_re_d  = '0;
      iss_z_im_d  = '0;
      iss_c_re_d  = re_acc_q;
      iss_c_im_d  = im_acc_q;
      iss_iter_d  = '0;
      iss_addr_d  = pix_addr_q;
    end

    if (inject) begin
      pix_addr_d = pix_addr_q + ADDR_WIDTH'(1);
      if (x_q == X_LAST) begin
        x_d      = '0;
        re_acc_d = re_start_q;
        y_d      = y_q + Y_W'(1);
        im_acc_d = im_acc_q + im_step_q;
      end else begin
        x_d      = x_q + X_W'(1);
        re_acc_d = re_acc_q + re_step_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          max_iter_d = (max_iter == '0) ? DATA_WIDTH'(1) : max_iter;
          re_start_d = re_start;
          re_step_d  = re_step;
          im_step_d  = im_step;
          x_d        = '0;
          y_d        = '0;
          pix_addr_d = '0;
          re_acc_d   = re_start;
          im_acc_d   = im_start;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (inject && last_pix) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!any_valid && !wr_en_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      max_iter_q  <= '0;
      re_start_q  <= '0;
      re_step_q   <= '0;
      im_step_q   <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pix_addr_q  <= '0;
      re_acc_q    <= '0;
      im_acc_q    <= '0;
      iss_valid_q <= 1'b0;
      iss_z_re_q  <= '0;
      iss_z_im_q  <= '0;
      iss_c_re_q  <= '0;
      iss_c_im_q  <= '0;
      iss_iter_q  <= '0;
      iss_addr_q  <= '0;
      sb_valid_q  <= '0;
      sb_c_re_q   <= '0;
      sb_c_im_q   <= '0;
      sb_iter_q   <= '0;
      sb_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      max_iter_q  <= max_iter_d;
      re_start_q  <= re_start_d;
      re_step_q   <= re_step_d;
      im_step_q   <= im_step_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_addr_q  <= pix_addr_d;
      re_acc_q    <= re_acc_d;
      im_acc_q    <= im_acc_d;
      iss_valid_q <= iss_valid_d;
      iss_z_re_q  <= iss_z_re_d;
      iss_z_im_q  <= iss_z_im_d;
      iss_c_re_q  <= iss_c_re_d;
      iss_c_im_q  <= iss_c_im_d;
      iss_iter_q  <= iss_iter_d;
      iss_addr_q  <= iss_addr_d;
      sb_valid_q  <= sb_valid_d;
      sb_c_re_q   <= sb_c_re_d;
      sb_c_im_q   <= sb_c_im_d;
      sb_iter_q   <= sb_iter_d;
      sb_addr_q   <= sb_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

`ifdef MANDEL_SCHED_STATS_EN
  logic [ADDR_WIDTH:0] in_set_count_q, in_set_count_d;

  always_comb begin
    in_set_count_d = in_set_count_q;
    if (start_acc) begin
      in_set_count_d = '0;
    end else if (retire && (wr_data_d == max_iter_q)) begin
      in_set_count_d = in_set_count_q + (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_set_count_q <= '0;
    end else begin
      in_set_count_q <= in_set_count_d;
    end
  end

  assign in_set_count = in_set_count_q;
`endif

  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign core_in_valid = iss_valid_q;
  assign core_z_re     = iss_z_re_q;
  assign core_z_im     = iss_z_im_q;
  assign core_c_re     = iss_c_re_q;
  assign core_c_im     = iss_c_im_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;

endmodule

// File: tb/tb_mandel_scheduler.sv
// tb/tb_mandel_scheduler.sv - scoreboard bench for mandel_scheduler with a toy fixed-latency core
// The core adds 1 to z_re each pass, so z_re on issue reveals the pass number.
module tb_mandel_scheduler;

  localparam int DW   = 8;
  localparam int AW   = 9;
  localparam int CW   = 16;
  localparam int HR   = 4;
  localparam int VR   = 2;
  localparam int LAT  = 4;
  localparam int NPIX = HR * VR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] max_iter = '0;
  logic [CW-1:0] re_start = '0, im_start = '0, re_step = '0, im_step = '0;
  logic          busy, done, core_in_valid;
  logic [CW-1:0] core_z_re, core_z_im, core_c_re, core_c_im;
  logic          core_out_valid, core_escaped;
  logic [CW-1:0] core_z_re_o, core_z_im_o;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
`ifdef MANDEL_SCHED_STATS_EN
  logic [AW:0]   in_set_count;
`endif

  mandel_scheduler #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COORD_WIDTH(CW),
    .H_RES(HR), .V_RES(VR), .CORE_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_iter(max_iter),
    .re_start(re_start), .im_start(im_start), .re_step(re_step), .im_step(im_step),
    .busy(busy), .done(done), .core_in_valid(core_in_valid),
    .core_z_re(core_z_re), .core_z_im(core_z_im), .core_c_re(core_c_re), .core_c_im(core_c_im),
    .core_out_valid(core_out_valid), .core_z_re_o(core_z_re_o), .core_z_im_o(core_z_im_o),
    .core_escaped(core_escaped), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef MANDEL_SCHED_STATS_EN
    , .in_set_count(in_set_count)
`endif
  );

  int total = 0;
  int bad = 0;
  int core_mode = 0;
  int cyc = 0;

  // mode 0: never escape, 1: always escape, 2: escape on pass 3 when c_re is odd
  logic [LAT-1:0]         cv = '0;
  logic [LAT-1:0]         cesc = '0;
  logic [LAT-1:0][CW-1:0] czr = '0;
  logic [LAT-1:0][CW-1:0] czi = '0;
  logic                   esc_new;
  assign esc_new = (core_mode == 1) || (core_mode == 2 && core_c_re[0] && core_z_re == CW'(2));

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    cv[0]   <= core_in_valid;
    cesc[0] <= esc_new;
    czr[0]  <= core_z_re + CW'(1);
    czi[0]  <= core_z_im;
    for (int k = 1; k < LAT; k++) begin
      cv[k]   <= cv[k-1];
      cesc[k] <= cesc[k-1];
      czr[k]  <= czr[k-1];
      czi[k]  <= czi[k-1];
    end
  end
  assign core_out_valid = cv[LAT-1];
  assign core_escaped   = cesc[LAT-1];
  assign core_z_re_o    = czr[LAT-1];
  assign core_z_im_o    = czi[LAT-1];

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [CW-1:0] exp_cre_q[$];
  logic [CW-1:0] exp_cim_q[$];
  int wr_cnt = 0, inj_cnt = 0, done_cnt = 0;
  int inj_first = -1, inj_last = -1, wr_first = -1;
  int widx;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      widx = -1;
      for (int i = 0; i < exp_addr_q.size(); i++) if (exp_addr_q[i] == wr_addr) widx = i;
      if (wr_first < 0) wr_first = cyc;
      wr_cnt++;
      total++;
      if (widx < 0) begin
        bad++;
        $display("FAIL wr_addr: got addr %0d (data %0d), required an outstanding frame address", wr_addr, wr_data);
      end else begin
        total++;
        if (wr_data !== exp_data_q[widx]) begin
          bad++;
          $display("FAIL wr_data: addr %0d got %0d required %0d", wr_addr, wr_data, exp_data_q[widx]);
        end
        exp_addr_q.delete(widx);
        exp_data_q.delete(widx);
      end
    end
    if (core_in_valid === 1'b1 && core_z_re == '0) begin
      if (inj_first < 0) inj_first = cyc;
      inj_last = cyc;
      inj_cnt++;
      total++;
      if (exp_cre_q.size() == 0) begin
        bad++;
        $display("FAIL inject: got stray new point c=(%h,%h), required none", core_c_re, core_c_im);
      end else begin
        total++;
        if (core_c_re !== exp_cre_q[0] || core_c_im !== exp_cim_q[0]) begin
          bad++;
          $display("FAIL inject_c: got (%h,%h) required (%h,%h)", core_c_re, core_c_im, exp_cre_q[0], exp_cim_q[0]);
        end
        void'(exp_cre_q.pop_front());
        void'(exp_cim_q.pop_front());
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic start_frame(input logic [DW-1:0] mi, input logic [CW-1:0] rs, input logic [CW-1:0] ims,
                             input logic [CW-1:0] rstp, input logic [CW-1:0] istp, input int mode);
    int eff;
    eff = (mi == 0) ? 1 : int'(mi);
    core_mode = mode;
    wr_cnt = 0; inj_cnt = 0; done_cnt = 0;
    inj_first = -1; inj_last = -1; wr_first = -1;
    for (int y = 0; y < VR; y++) begin
      for (int x = 0; x < HR; x++) begin
        int a;
        int d;
        a = y * HR + x;
        if (mode == 1) d = 0;
        else if (mode == 2 && (a % 2) == 1) d = (eff > 2) ? 2 : eff;
        else d = eff;
        exp_addr_q.push_back(AW'(a));
        exp_data_q.push_back(DW'(d));
        exp_cre_q.push_back(rs + CW'(x) * rstp);
        exp_cim_q.push_back(ims + CW'(y) * istp);
      end
    end
    @(negedge clk);
    max_iter = mi; re_start = rs; im_start = ims; re_step = rstp; im_step = istp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", done); end
    total++; if (core_in_valid !== 1'b0) begin bad++; $display("FAIL reset_in_valid: got %b required 0", core_in_valid); end
    total++; if ({wr_en, wr_addr, wr_data} !== '0) begin bad++; $display("FAIL reset_wr: got en=%b addr=%0d data=%0d required 0", wr_en, wr_addr, wr_data); end
    total++; if ({core_z_re, core_z_im, core_c_re, core_c_im} !== '0) begin bad++; $display("FAIL reset_operands: got nonzero core operands, required 0"); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_never_escape();
    bit ok;
    start_frame(8'd5, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL never_busy_rise: got %b required 1", busy); end
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL never_done_timeout: got no done, required done within 400 cycles"); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL never_busy_at_done: got %b required 0", busy); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL never_done_width: got %b required 0", done); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL never_done_count: got %0d required 1", done_cnt); end
    total++; if (wr_cnt != NPIX || exp_addr_q.size() != 0) begin bad++; $display("FAIL never_writes: got %0d writes, %0d outstanding, required %0d and 0", wr_cnt, exp_addr_q.size(), NPIX); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL never_busy_after: got %b required 0", busy); end
  endtask

  task automatic test_all_escape();
    bit ok;
    start_frame(8'd5, 16'h2000, 16'h2000, 16'h0001, 16'h0010, 1);
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL esc_done_timeout: got no done, required done within 400 cycles"); end
    @(negedge clk);
    total++; if (wr_first - inj_first != LAT + 1) begin bad++; $display("FAIL esc_latency: got %0d required %0d", wr_first - inj_first, LAT + 1); end
    total++; if (inj_cnt != NPIX || inj_last - inj_first != NPIX - 1) begin bad++; $display("FAIL esc_back_to_back: got %0d injects over %0d cycles, required %0d over %0d", inj_cnt, inj_last - inj_first + 1, NPIX, NPIX); end
    total++; if (wr_cnt != NPIX || exp_addr_q.size() != 0) begin bad++; $display("FAIL esc_writes: got %0d writes, %0d outstanding, required %0d and 0", wr_cnt, exp_addr_q.size(), NPIX); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL esc_done_count: got %0d required 1", done_cnt); end
  endtask

  task automatic test_mixed();
    bit ok;
    start_frame(8'd4, 16'h0000, 16'h0000, 16'h0001, 16'h0010, 2);
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL mixed_done_timeout: got no done, required done within 400 cycles"); end
    @(negedge clk);
    total++; if (wr_cnt != NPIX || exp_addr_q.size() != 0) begin bad++; $display("FAIL mixed_writes: got %0d writes, %0d outstanding, required %0d and 0", wr_cnt, exp_addr_q.size(), NPIX); end
    total++; if (inj_cnt != NPIX || exp_cre_q.size() != 0) begin bad++; $display("FAIL mixed_injects: got %0d required %0d", inj_cnt, NPIX); end
`ifdef MANDEL_SCHED_STATS_EN
    total++; if (in_set_count !== (AW+1)'(4)) begin bad++; $display("FAIL mixed_in_set_count: got %0d required 4", in_set_count); end
`endif
  endtask

  task automatic test_max_iter_zero();
    bit ok;
    start_frame(8'd0, 16'h7FFE, 16'h8000, 16'h0001, 16'hFFFF, 0);
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_done_timeout: got no done, required done within 400 cycles"); end
    @(negedge clk);
    total++; if (wr_cnt != NPIX || exp_addr_q.size() != 0) begin bad++; $display("FAIL zero_writes: got %0d writes, %0d outstanding, required %0d and 0", wr_cnt, exp_addr_q.size(), NPIX); end
  endtask

  task automatic test_start_ignored();
    bit ok;
    start_frame(8'd6, 16'h0000, 16'h0000, 16'h0001, 16'h0010, 0);
    repeat (3) @(negedge clk);
    max_iter = 8'd2; re_start = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ignored_busy: got %b required 1", busy); end
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL ignored_done_timeout: got no done, required done within 400 cycles"); end
    @(negedge clk);
    total++; if (wr_cnt != NPIX || exp_addr_q.size() != 0) begin bad++; $display("FAIL ignored_writes: got %0d writes, %0d outstanding, required %0d and 0", wr_cnt, exp_addr_q.size(), NPIX); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ignored_done_count: got %0d required 1", done_cnt); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    start_frame(8'd6, 16'h0000, 16'h0000, 16'h0001, 16'h0010, 0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, core_in_valid, wr_en} !== 4'b0000) begin bad++; $display("FAIL abort_ctrl: got busy/done/valid/wr=%b required 0000", {busy, done, core_in_valid, wr_en}); end
    total++; if ({wr_addr, wr_data, core_z_re, core_c_re, core_c_im} !== '0) begin bad++; $display("FAIL abort_data: got nonzero write/operand outputs, required 0"); end
    exp_addr_q.delete(); exp_data_q.delete(); exp_cre_q.delete(); exp_cim_q.delete();
    wr_cnt = 0; inj_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (wr_cnt != 0 || inj_cnt != 0) begin bad++; $display("FAIL abort_quiet: got %0d writes %0d injects, required 0 and 0", wr_cnt, inj_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b required 0", busy); end
    start_frame(8'd3, 16'h0100, 16'h0000, 16'h0001, 16'hFFF0, 2);
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL after_abort_timeout: got no done, required done within 400 cycles"); end
    @(negedge clk);
    total++; if (wr_cnt != NPIX || exp_addr_q.size() != 0) begin bad++; $display("FAIL after_abort_writes: got %0d writes, %0d outstanding, required %0d and 0", wr_cnt, exp_addr_q.size(), NPIX); end
  endtask

  initial begin
    test_reset();
    test_never_escape();
    test_all_escape();
    test_mixed();
    test_max_iter_zero();
    test_start_ignored();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mandel_scheduler.md
Name: mandel_scheduler

Overview:
- Parametrised successor to the single-core Mandelbrot frame filler.
- Owns one frame: generates c coordinates from a programmable window and feeds points into an external fixed-latency z²+c iteration core.
- Recirculates each point around the core until it escapes or reaches a runtime max iteration count, then writes the count to the frame-buffer write port.
- Adds a start/busy/done handshake, runtime window and iteration limit, and configurable resolution and core latency.

Parameters:
- DATA_WIDTH, 8: iteration count width (frame buffer word).
- ADDR_WIDTH, 9: frame-buffer address width.
- COORD_WIDTH, 16: signed fixed-point width of c and z components.
- H_RES, 32: pixels per row.
- V_RES, 16: rows per frame. H_RES*V_RES must be ≤ 2^ADDR_WIDTH.
- CORE_LAT, 4: cycles from core_in_valid to matching core_out_valid. Must be ≥ 1.

Ports:
- clk, input, 1: sole clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: frame request pulse, accepted only in IDLE.
- max_iter, input, DATA_WIDTH: iteration limit; sampled at start; a value of 0 is treated as 1.
- re_start / im_start, input, COORD_WIDTH: c of pixel (0,0); sampled at start.
- re_step / im_step, input, COORD_WIDTH: signed per-column / per-row increments; sampled at start.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse after the final write.
- core_in_valid, output, 1: issue point to core.
- core_z_re / core_z_im / core_c_re / core_c_im, output, COORD_WIDTH each: operands issued to the core.
- core_out_valid, input, 1: core result valid, exactly CORE_LAT cycles after issue.
- core_z_re_o / core_z_im_o, input, COORD_WIDTH: z²+c result.
- core_escaped, input, 1: |result|² > 4.
- wr_en, output, 1: frame-buffer write strobe.
- wr_addr, output, ADDR_WIDTH: write address.
- wr_data, output, DATA_WIDTH: iteration count.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, sideband delay line invalid. Reset mid-frame aborts the frame with no further writes; the core's in-flight results are ignored via the invalid sideband.
- FSM states:
  - IDLE: start → RUN. Latch the window registers and max_iter. Set x=y=0, pix_addr=0, re_acc=re_start, im_acc=im_start.
  - RUN: inject and recirculate points. When the last pixel has been issued → DRAIN.
  - DRAIN: recirculate only. When no slot is valid and no write is pending → DONE.
  - DONE: done=1 for one cycle; busy falls the same cycle → IDLE.
- start while busy is ignored.
- Sideband delay line (depth CORE_LAT) carries per slot: valid, c_re, c_im, iter, addr. It aligns with core outputs on core_out_valid.
- Slot decision each cycle, on the returning slot (sideband valid at tail):
  - core_escaped=1 → retire with wr_data=iter.
  - Not escaped and iter+1 == max_iter → retire with wr_data=max_iter.
  - Otherwise → recirculate: z=core result, same c and addr, iter+1.
- Issue priority:
  - A recirculating slot always wins.
  - If no slot is returning, or the returning slot retires, the issue slot takes a new pixel if one remains (RUN). The new pixel is issued with z=0, iter=0, c=(re_acc, im_acc), addr=pix_addr.
  - Otherwise a bubble is issued (core_in_valid=0).
- Pixel advance on inject:
  - x++ and re_acc += re_step.
  - At x==H_RES-1: x=0, re_acc=re_start, y++, im_acc += im_step.
  - pix_addr++.
  - Last pixel is x==H_RES-1, y==V_RES-1.
- Coordinate arithmetic is two's-complement and wraps modulo 2^COORD_WIDTH with no saturation.
- Writes are registered: wr_en/wr_addr/wr_data appear 1 cycle after the retiring core_out_valid. At most one write per cycle. Writes occur in completion order, not raster order.
- Latency: in an empty pipe, a point escaping on pass 1 issued at cycle t produces wr_en at t+CORE_LAT+1.
- Each frame address is written exactly once.

Optional Feature:
- Macro MANDEL_SCHED_STATS_EN.
- When defined, adds output in_set_count (ADDR_WIDTH+1 bits):
  - Cleared on accepted start.
  - Incremented on each retire with wr_data==max_iter.
  - Holds its value after done until the next start.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset then start: window (0,0) step 0, max_iter=5, core model never escapes, H_RES=4, V_RES=2 → 8 writes, addrs 0..7 each exactly once, wr_data=5; done pulse once; busy low after.
- All-escape: re_start=im_start=2.0, max_iter=5 → first write at issue+CORE_LAT+1, every wr_data=0, back-to-back injects with no bubbles, done after 8 writes.
- Mixed: escape on pass 3 for odd addresses, never for even ones, max_iter=4 → odd addrs wr_data=2, even addrs wr_data=4; recirculation never loses or duplicates a pixel.
- max_iter=0 with a non-escaping core → treated as 1, all wr_data=1.
- start asserted during RUN is ignored; rst_n dropped mid-RUN → all outputs 0 immediately, no wr_en until the next start, and the next frame completes normally.
- Stats (MANDEL_SCHED_STATS_EN): mixed case above → in_set_count=4 at done.
